// File: rtl/maple_tx_framer_if.sv
// maple_tx_framer_if: host word feed and encoder byte interface of the Maple TX framer
interface maple_tx_framer_if;
  logic        start;
  logic [31:0] header;
  logic [31:0] word_data;
  logic        word_valid;
  logic        word_ready;
  logic        enc_enable;
  logic [7:0]  data;
  logic        empty;
  logic        next;
  logic        enc_done;
  logic        busy;
  logic        frame_done;
  logic        err;
  modport master (
    output start, header, word_data, word_valid, next, enc_done,
    input  word_ready, enc_enable, data, empty, busy, frame_done, err
  );
  modport slave (
    input  start, header, word_data, word_valid, next, enc_done,
    output word_ready, enc_enable, data, empty, busy, frame_done, err
  );
endinterface

// File: rtl/maple_tx_framer.sv
// maple_tx_framer: serialises header + payload words into bytes for the Maple encoder.
// Define MAPLE_TX_CRC_EN to append the XOR CRC byte after the payload.
module maple_tx_framer #(
  parameter int MAX_WORDS = 255
) (
  input logic clk,
  input logic reset,
  maple_tx_framer_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE,
    HDR,
    PAY,
`ifdef MAPLE_TX_CRC_EN
    CRC,
`endif
    WAIT_DONE
  } state_t;
  state_t      r_state;
  logic [31:0] r_hdr;
  logic [31:0] r_hold;
  logic        r_hold_v;
  logic [1:0]  r_byte_cnt;
  logic [7:0]  r_word_cnt;
  logic [7:0]  r_fetch_cnt;
  logic [7:0]  r_data;
  logic        r_empty;
  logic        r_enc_enable;
  logic        r_busy;
  logic        r_frame_done;
  logic        r_err;
`ifdef MAPLE_TX_CRC_EN
  logic [7:0]  r_crc;
`endif
  logic [7:0]  w_len;
  logic        w_word_ready;
  logic        w_take;
  logic        w_hold_v;
  logic [31:0] w_hold;
  logic        w_adv;
  state_t      w_end_state;
  logic [7:0]  w_end_data;
  logic        w_end_empty;
  function automatic logic [7:0] sel(input logic [31:0] w, input logic [1:0] b);
    return w[{b, 3'b000} +: 8];
  endfunction
  assign w_len = r_hdr[7:0];
  // the holding register is released once its last byte moves into r_data, so the next word can prefetch
  assign w_word_ready = (r_state == HDR || r_state == PAY) && !r_hold_v && (r_fetch_cnt != w_len);
  assign w_take   = bus.word_valid && w_word_ready;
  assign w_hold_v = r_hold_v || w_take;
  assign w_hold   = r_hold_v ? r_hold : bus.word_data;
  assign w_adv    = bus.next && !r_empty;
`ifdef MAPLE_TX_CRC_EN
  assign w_end_state = CRC;
  assign w_end_data  = r_crc ^ r_data;
  assign w_end_empty = 1'b0;
`else
  assign w_end_state = WAIT_DONE;
  assign w_end_data  = r_data;
  assign w_end_empty = 1'b1;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_hdr        <= '0;
      r_hold       <= '0;
      r_hold_v     <= 1'b0;
      r_byte_cnt   <= '0;
      r_word_cnt   <= '0;
      r_fetch_cnt  <= '0;
      r_data       <= '0;
      r_empty      <= 1'b1;
      r_enc_enable <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
`ifdef MAPLE_TX_CRC_EN
      r_crc        <= '0;
`endif
    end else begin
      r_enc_enable <= 1'b0;
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
      if (w_take) begin
        r_hold      <= bus.word_data;
        r_hold_v    <= 1'b1;
        r_fetch_cnt <= r_fetch_cnt + 8'd1;
      end
`ifdef MAPLE_TX_CRC_EN
      if (w_adv) r_crc <= r_crc ^ r_data;
`endif
      case (r_state)
        IDLE: if (bus.start) begin
          if (int'(bus.header[7:0]) > MAX_WORDS) r_err <= 1'b1;
          else begin
            r_hdr        <= bus.header;
            r_data       <= bus.header[7:0];
            r_empty      <= 1'b0;
            r_byte_cnt   <= '0;
            r_word_cnt   <= '0;
            r_fetch_cnt  <= '0;
            r_hold_v     <= 1'b0;
            r_enc_enable <= 1'b1;
            r_busy       <= 1'b1;
            r_state      <= HDR;
`ifdef MAPLE_TX_CRC_EN
            r_crc        <= '0;
`endif
          end
        end
        HDR: if (w_adv) begin
          if (r_byte_cnt == 2'd3) begin
            r_byte_cnt <= '0;
            if (w_len != 8'd0) begin
              r_state <= PAY;
              r_data  <= w_hold_v ? w_hold[7:0] : r_data;
              r_empty <= !w_hold_v;
            end else begin
              r_state <= w_end_state;
              r_data  <= w_end_data;
              r_empty <= w_end_empty;
            end
          end else begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            r_data     <= sel(r_hdr, r_byte_cnt + 2'd1);
          end
        end
        PAY: if (w_adv) begin
          if (r_byte_cnt == 2'd3) begin
            r_byte_cnt <= '0;
            r_word_cnt <= r_word_cnt + 8'd1;
            if (r_word_cnt + 8'd1 == w_len) begin
              r_state <= w_end_state;
              r_data  <= w_end_data;
              r_empty <= w_end_empty;
            end else begin
              r_data  <= w_hold_v ? w_hold[7:0] : r_data;
              r_empty <= !w_hold_v;
            end
          end else begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            r_data     <= sel(r_hold, r_byte_cnt + 2'd1);
            if (r_byte_cnt == 2'd2) r_hold_v <= 1'b0;
          end
        end else if (r_empty && w_hold_v) begin
          r_data  <= w_hold[7:0];
          r_empty <= 1'b0;
        end
`ifdef MAPLE_TX_CRC_EN
        CRC: if (w_adv) begin
          r_empty <= 1'b1;
          r_state <= WAIT_DONE;
        end
`endif
        WAIT_DONE: if (bus.enc_done) begin
          r_frame_done <= 1'b1;
          r_busy       <= 1'b0;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
      // encoder finished early: it hit an empty byte boundary, so the frame is lost
      if (bus.enc_done && r_state != IDLE && r_state != WAIT_DONE) begin
        r_err    <= 1'b1;
        r_state  <= IDLE;
        r_empty  <= 1'b1;
        r_busy   <= 1'b0;
        r_hold_v <= 1'b0;
      end
    end
  end
  assign bus.word_ready = w_word_ready;
  assign bus.enc_enable = r_enc_enable;
  assign bus.data       = r_data;
  assign bus.empty      = r_empty;
  assign bus.busy       = r_busy;
  assign bus.frame_done = r_frame_done;
  assign bus.err        = r_err;
endmodule

// File: tb/tb_maple_tx_framer.sv
// tb_maple_tx_framer: scoreboard bench with an encoder model consuming bytes and a host word feeder
module tb_maple_tx_framer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  maple_tx_framer_if bus ();
  maple_tx_framer_if rbus ();
  maple_tx_framer u_dut (.clk(clk), .reset(reset), .bus(bus));
  maple_tx_framer #(.MAX_WORDS(2)) u_rej (.clk(clk), .reset(reset), .bus(rbus));
  int n_run = 0;
  int n_fail = 0;
  int n_en = 0;
  int n_fd = 0;
  int n_err = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] word_q[$];
  logic [31:0] pay[$];
  bit xfer = 0;
  bit cons_en = 1;
  bit noise = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    logic [8:0] e;
    @(negedge clk);
    if (xfer) void'(word_q.pop_front());
    bus.word_valid = word_q.size() > 0;
    bus.word_data  = word_q.size() > 0 ? word_q[0] : 32'h0;
    xfer = bus.word_valid && bus.word_ready;
    if (bus.enc_enable) begin
      n_en++;
      check("enable_first_byte", bus.empty, 0);
    end
    if (bus.frame_done) n_fd++;
    if (bus.err) n_err++;
    if (noise && bus.busy) begin
      bus.start  = ~bus.start;
      bus.header = $urandom;
    end
    if (bus.next) bus.next = 1'b0;
    else if (cons_en && !bus.empty) begin
      e = exp_q.size() > 0 ? {1'b0, exp_q.pop_front()} : 9'h1ff;
      check("byte", {1'b0, bus.data}, e);
      bus.next = 1'b1;
    end else if (noise && bus.empty) bus.next = 1'b1;
  endtask
  task automatic push_frame(input logic [31:0] hdr, input bit with_crc);
    logic [7:0] c = 8'h0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(hdr[i*8 +: 8]);
      c ^= hdr[i*8 +: 8];
    end
    foreach (pay[k]) begin
      word_q.push_back(pay[k]);
      for (int i = 0; i < 4; i++) begin
        exp_q.push_back(pay[k][i*8 +: 8]);
        c ^= pay[k][i*8 +: 8];
      end
    end
`ifdef MAPLE_TX_CRC_EN
    if (with_crc) exp_q.push_back(c);
`endif
  endtask
  task automatic drain(input string tag);
    for (int i = 0; i < 200 && !(exp_q.size() == 0 && bus.empty); i++) step();
    check(tag, exp_q.size(), 0);
  endtask
  task automatic do_frame(input string tag, input logic [31:0] hdr, input bit noise_on);
    int en0, fd0;
    en0 = n_en;
    fd0 = n_fd;
    push_frame(hdr, 1'b1);
    bus.header = hdr;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    noise = noise_on;
    drain(tag);
    step();
    step();
    check("busy_wait_done", bus.busy, 1);
    check("empty_wait_done", bus.empty, 1);
    bus.enc_done = 1'b1;
    step();
    bus.enc_done = 1'b0;
    noise = 1'b0;
    bus.start = 1'b0;
    bus.next = 1'b0;
    check("frame_done", n_fd - fd0, 1);
    check("enc_enable_count", n_en - en0, 1);
    check("busy_after_done", bus.busy, 0);
    step();
    check("frame_done_pulse", bus.frame_done, 0);
  endtask
  initial begin
    int err0;
    bus.start = 0; bus.header = 0; bus.word_data = 0; bus.word_valid = 0; bus.next = 0; bus.enc_done = 0;
    rbus.start = 0; rbus.header = 0; rbus.word_data = 0; rbus.word_valid = 0; rbus.next = 0; rbus.enc_done = 0;
    step();
    step();
    check("rst_data", bus.data, 0);
    check("rst_empty", bus.empty, 1);
    check("rst_enable", bus.enc_enable, 0);
    check("rst_ready", bus.word_ready, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_fdone", bus.frame_done, 0);
    check("rst_err", bus.err, 0);
    reset = 1'b0;
    step();
    pay = '{32'hAABBCCDD};
    do_frame("s1_frame", 32'h0C200101, 1'b0);
    pay = '{};
    do_frame("s2_len0", 32'h01200000, 1'b0);
    pay = '{32'h01234567, 32'h89ABCDEF, 32'h5A5AA5A5};
    do_frame("s1b_three_words", 32'h0D2A1503, 1'b0);
    rbus.header = 32'h0C200103;
    rbus.start = 1'b1;
    step();
    rbus.start = 1'b0;
    check("rej_err", rbus.err, 1);
    check("rej_busy", rbus.busy, 0);
    check("rej_empty", rbus.empty, 1);
    check("rej_enable", rbus.enc_enable, 0);
    step();
    check("rej_err_pulse", rbus.err, 0);
    check("rej_busy_later", rbus.busy, 0);
    rbus.header = 32'h0C200102;
    rbus.start = 1'b1;
    step();
    rbus.start = 1'b0;
    check("max_len_busy", rbus.busy, 1);
    check("max_len_enable", rbus.enc_enable, 1);
    check("max_len_err", rbus.err, 0);
    err0 = n_err;
    pay = '{32'h11223344};
    push_frame(32'h0C200102, 1'b0);
    bus.header = 32'h0C200102;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    drain("s4_first_word");
    step();
    step();
    check("underrun_empty", bus.empty, 1);
    check("underrun_busy", bus.busy, 1);
    check("underrun_ready", bus.word_ready, 1);
    bus.enc_done = 1'b1;
    step();
    bus.enc_done = 1'b0;
    check("underrun_err", n_err - err0, 1);
    check("underrun_idle", bus.busy, 0);
    check("underrun_fdone", n_fd, 3);
    pay = '{32'hAABBCCDD};
    do_frame("s4_recover", 32'h0C200101, 1'b0);
    pay = '{32'hCAFEF00D, 32'h0BADBEEF};
    push_frame(32'h0C200102, 1'b1);
    bus.header = 32'h0C200102;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 13; i++) step();
    reset = 1'b1;
    step();
    bus.next = 1'b0;
    exp_q.delete();
    word_q.delete();
    xfer = 0;
    bus.word_valid = 1'b0;
    check("mid_rst_empty", bus.empty, 1);
    check("mid_rst_data", bus.data, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_ready", bus.word_ready, 0);
    check("mid_rst_err", bus.err, 0);
    reset = 1'b0;
    pay = '{32'hAABBCCDD};
    do_frame("s5_after_reset", 32'h0C200101, 1'b0);
    err0 = n_err;
    do_frame("s6_noise", 32'h0C200101, 1'b1);
    check("noise_no_err", n_err - err0, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
